elixirchip_es1_spu_result_fifo: RTL and testbench
=================================================

ELIXIRCHIP_ES1_SPU_RESULT_FIFO -- requirements
Module: elixirchip_es1_spu_result_fifo

Interface
REQ-001 The block SHALL have these parameters:
- DATA_BITS, 8, result word width.
- DEPTH, 16, number of FIFO entries; power of two, at least 2.
- ALMOST_FULL_LEVEL, DEPTH-2, occupancy at or above which almost_full asserts.
- DEVICE, "RTL", device name (no functional effect).
- SIMULATION, "false", simulation flag (no functional effect).
- DEBUG, "false", debug flag (no functional effect).

REQ-002 The block SHALL have these ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous reset, active low.
- cke  in  1  clock enable for the SPU (write) side only.
- s_data  in  DATA_BITS  result word from the upstream SPU op stage (its m_data).
- s_valid  in  1  s_data is valid in this cke cycle.
- s_clear  in  1  flush request, sampled in a cke cycle.
- m_data  out  DATA_BITS  head-of-FIFO word.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  consumer accepts m_data.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= ALMOST_FULL_LEVEL.
- overflow  out  1  sticky: at least one push was dropped.

Function
REQ-003 Push SHALL be cke && s_valid; no ready is returned to the SPU side, and upstream throttles cke using almost_full.
REQ-004 Pop SHALL be m_valid && m_ready, independent of cke.
REQ-005 A push SHALL store s_data at the write pointer, and both pointers SHALL wrap modulo DEPTH.
REQ-006 A push while count==DEPTH with no pop in the same cycle SHALL be dropped: the contents are unchanged and overflow is set to 1.
REQ-007 A push while count==DEPTH with a simultaneous pop SHALL be accepted, and count SHALL stay at DEPTH.
REQ-008 A push and pop in the same cycle with 0<count<DEPTH SHALL leave count unchanged.
REQ-009 A push into an empty FIFO SHALL raise m_valid on the next clk edge, with 1-cycle latency and no same-cycle bypass.
REQ-010 m_valid SHALL equal (count!=0), and m_data SHALL show the oldest entry whenever m_valid=1 (first-word-fall-through).
REQ-011 m_data SHALL hold its value while m_valid=1 and m_ready=0, regardless of cke or pushes.
REQ-012 cke && s_clear SHALL flush the FIFO on that edge: both pointers reset, count=0 and overflow=0.
REQ-013 A pop in the same cycle as a flush SHALL be discarded.
REQ-014 cke && s_clear && s_valid SHALL flush and then push s_data, so count=1 after the edge.
REQ-015 s_clear with cke=0 SHALL have no effect.
REQ-016 s_valid and s_data SHALL be ignored when cke=0.
REQ-017 almost_full and count SHALL be registered and consistent with the post-edge occupancy.
REQ-018 m_data when m_valid=0 SHALL be don't-care.

Reset
REQ-019 While reset_n=0, asynchronously: pointers=0, count=0, m_valid=0, almost_full=0, overflow=0; storage contents are not reset.
REQ-020 Deassertion of reset_n SHALL be synchronous to clk, and the first push SHALL be accepted on the first rising edge with reset_n=1.
REQ-021 Assertion of reset_n mid-operation SHALL discard all contents, and m_valid SHALL fall immediately without waiting for clk.

Verification (DEPTH=4, ALMOST_FULL_LEVEL=2, DATA_BITS=8)
REQ-022 Push 0x11, 0x22, 0x33 with cke=1 and m_ready=0 -> count 1,2,3; almost_full=1 from count 2; m_data=0x11 held; then m_ready=1 -> 0x11, 0x22, 0x33 popped in order; m_valid=0 after.
REQ-023 Push 5 words 0xA0..0xA4 with m_ready=0 -> count saturates at 4; 0xA4 dropped; overflow=1 and stays 1; drain yields 0xA0..0xA3.
REQ-024 FIFO full and m_ready=1, push 0xB5 -> pop and push in the same cycle; count stays 4; 0xB5 emerges 4th after draining.
REQ-025 Hold count=3, cke=1, s_clear=1, s_valid=1, s_data=0x5A -> next cycle count=1, m_data=0x5A, overflow=0.
REQ-026 Random cke (90% high) with s_valid and m_ready random for 1000 cycles -> output sequence equals the scoreboard of accepted pushes; no word emitted without a matching push.
REQ-027 Pull reset_n low while count=2 -> m_valid=0 and count=0 within the same cycle; first push after release appears on m_data one cycle later.

Source files
------------

// File: rtl/elixirchip_es1_spu_result_fifo.sv
// elixirchip_es1_spu_result_fifo: first-word-fall-through result FIFO with cke-gated write side, flush and sticky overflow
module elixirchip_es1_spu_result_fifo #(
    parameter int    DATA_BITS         = 8,
    parameter int    DEPTH             = 16,
    parameter int    ALMOST_FULL_LEVEL = DEPTH - 2,
    parameter string DEVICE            = "RTL",
    parameter string SIMULATION        = "false",
    parameter string DEBUG             = "false"
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cke,
    input  logic [DATA_BITS-1:0]       s_data,
    input  logic                       s_valid,
    input  logic                       s_clear,
    output logic [DATA_BITS-1:0]       m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (SIMULATION == "true" || DEBUG == "true" || DEVICE == "") begin : g_flags
    end

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
    logic [CW-1:0]        count_q, count_d;
    logic                 overflow_q, overflow_d, almost_full_q;
    logic                 flush, push, pop, full, accept;

    // A flush wins over a pop; a push into a full FIFO only lands if a pop frees the slot
    always_comb begin
        flush      = cke && s_clear;
        push       = cke && s_valid;
        full       = count_q == CW'(DEPTH);
        pop        = (count_q != '0) && m_ready && !flush;
        accept     = push && (flush || !full || pop);
        wr_addr    = flush ? '0 : wr_ptr_q;
        wr_ptr_d   = wr_addr + AW'(accept);
        rd_ptr_d   = flush ? '0 : rd_ptr_q + AW'(pop);
        count_d    = (flush ? '0 : count_q - CW'(pop)) + CW'(accept);
        overflow_d = !flush && (overflow_q || (push && !accept));
    end

    // Pointer, occupancy and flag state, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            almost_full_q <= count_d >= CW'(ALMOST_FULL_LEVEL);
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_addr] <= s_data;
    end

    assign m_data      = mem_q[rd_ptr_q];
    assign m_valid     = count_q != '0;
    assign count       = count_q;
    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_elixirchip_es1_spu_result_fifo.sv
// tb_elixirchip_es1_spu_result_fifo: vector table, corner sequences and randomized queue-model check
module tb_elixirchip_es1_spu_result_fifo;
    logic       clk = 1'b0, reset_n = 1'b0, cke = 1'b0, s_valid = 1'b0, s_clear = 1'b0, m_ready = 1'b0;
    logic [7:0] s_data = '0, m_data;
    logic       m_valid, almost_full, overflow;
    logic [2:0] count;

    always #5 clk = ~clk;

    elixirchip_es1_spu_result_fifo #(.DATA_BITS(8), .DEPTH(4), .ALMOST_FULL_LEVEL(2)) dut (
        .clk(clk), .reset_n(reset_n), .cke(cke), .s_data(s_data), .s_valid(s_valid), .s_clear(s_clear),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count),
        .almost_full(almost_full), .overflow(overflow)
    );

    typedef struct {
        bit c, v, cl, r;
        logic [7:0] d;
        int cnt;
        bit mv;
        logic [7:0] md;
        bit af, ov;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] q[$];
    bit         ov_m;
    int         vectors = 0, miscompares = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(bit c, bit v, bit cl, bit r, logic [7:0] d);
        cke = c; s_valid = v; s_clear = cl; m_ready = r; s_data = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(bit c, bit v, bit cl, bit r, logic [7:0] d, int cnt, bit mv, logic [7:0] md, bit af, bit ov);
        tbl.push_back('{c, v, cl, r, d, cnt, mv, md, af, ov});
    endtask

    // Queue-level behaviour: flush then optional push; otherwise pop first, then push if a slot is free
    task automatic model_step(bit c, bit v, bit cl, bit r, logic [7:0] d);
        if (c && cl) begin
            q.delete();
            ov_m = 0;
            if (v) q.push_back(d);
        end else begin
            if (q.size() != 0 && r) void'(q.pop_front());
            if (c && v) begin
                if (q.size() < 4) q.push_back(d);
                else ov_m = 1;
            end
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".m_valid"}, 32'(m_valid), 32'(q.size() != 0));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(q.size() >= 2));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ov_m));
        if (q.size() != 0) chk({tag, ".m_data"}, 32'(m_data), 32'(q[0]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        add(1,1,0,0,8'h11, 1,1,8'h11,0,0);
        add(1,1,0,0,8'h22, 2,1,8'h11,1,0);
        add(1,1,0,0,8'h33, 3,1,8'h11,1,0);
        add(0,0,0,0,8'h00, 3,1,8'h11,1,0);
        add(0,1,0,0,8'h99, 3,1,8'h11,1,0);
        add(0,0,1,0,8'h00, 3,1,8'h11,1,0);
        add(1,0,0,1,8'h00, 2,1,8'h22,1,0);
        add(1,0,0,1,8'h00, 1,1,8'h33,0,0);
        add(1,0,0,1,8'h00, 0,0,8'h00,0,0);
        add(1,1,0,0,8'hA0, 1,1,8'hA0,0,0);
        add(1,1,0,0,8'hA1, 2,1,8'hA0,1,0);
        add(1,1,0,0,8'hA2, 3,1,8'hA0,1,0);
        add(1,1,0,0,8'hA3, 4,1,8'hA0,1,0);
        add(1,1,0,0,8'hA4, 4,1,8'hA0,1,1);
        add(1,0,0,0,8'h00, 4,1,8'hA0,1,1);
        add(1,1,0,1,8'hB5, 4,1,8'hA1,1,1);
        add(1,0,0,1,8'h00, 3,1,8'hA2,1,1);
        add(1,0,0,1,8'h00, 2,1,8'hA3,1,1);
        add(1,0,0,1,8'h00, 1,1,8'hB5,0,1);
        add(1,0,0,1,8'h00, 0,0,8'h00,0,1);
        add(1,1,0,0,8'hC1, 1,1,8'hC1,0,1);
        add(1,1,0,0,8'hC2, 2,1,8'hC1,1,1);
        add(1,1,0,0,8'hC3, 3,1,8'hC1,1,1);
        add(1,1,1,1,8'h5A, 1,1,8'h5A,0,0);
        add(0,1,1,1,8'h77, 0,0,8'h00,0,0);
        add(1,1,0,0,8'h66, 1,1,8'h66,0,0);
        add(1,0,1,0,8'h00, 0,0,8'h00,0,0);

        #3;
        chk("reset.count", 32'(count), 0);
        chk("reset.m_valid", 32'(m_valid), 0);
        chk("reset.almost_full", 32'(almost_full), 0);
        chk("reset.overflow", 32'(overflow), 0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].v, tbl[i].cl, tbl[i].r, tbl[i].d);
            step();
            chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.m_valid", i), 32'(m_valid), 32'(tbl[i].mv));
            chk($sformatf("tbl%0d.almost_full", i), 32'(almost_full), 32'(tbl[i].af));
            chk($sformatf("tbl%0d.overflow", i), 32'(overflow), 32'(tbl[i].ov));
            if (tbl[i].mv) chk($sformatf("tbl%0d.m_data", i), 32'(m_data), 32'(tbl[i].md));
        end

        q.delete();
        ov_m = 0;
        for (int n = 0; n < 1000; n++) begin
            bit c, v, cl, r;
            logic [7:0] d;
            c  = $urandom_range(0, 9) != 0;
            v  = 1'($urandom);
            cl = $urandom_range(0, 63) == 0;
            r  = $urandom_range(0, 2) != 0;
            d  = 8'($urandom);
            drive(c, v, cl, r, d);
            model_step(c, v, cl, r, d);
            step();
            check_model($sformatf("rnd%0d", n));
        end

        drive(1, 0, 1, 0, 8'h00);
        model_step(1, 0, 1, 0, 8'h00);
        step();
        drive(1, 1, 0, 0, 8'h31);
        model_step(1, 1, 0, 0, 8'h31);
        step();
        drive(1, 1, 0, 0, 8'h32);
        model_step(1, 1, 0, 0, 8'h32);
        step();
        check_model("pre_reset");
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset.m_valid", 32'(m_valid), 0);
        chk("midreset.count", 32'(count), 0);
        chk("midreset.almost_full", 32'(almost_full), 0);
        chk("midreset.overflow", 32'(overflow), 0);
        q.delete();
        ov_m = 0;
        drive(1, 1, 0, 0, 8'h44);
        @(negedge clk);
        reset_n = 1'b1;
        model_step(1, 1, 0, 0, 8'h44);
        step();
        check_model("post_reset");
        drive(0, 0, 0, 0, 8'h00);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
